// File: rtl/dither_demod_v1.sv
// Square-wave dither demodulator: averages H and L half-periods after a settle
// interval and reports (H-L)/2 and (H+L)/2. Optional integrator: DEMOD_INTEG_EN.
module dither_demod_v1 #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_trig,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic signed [DATA_W-1:0] i_dither,
  input  logic        [31:0]       i_wait_cnt,
  input  logic        [31:0]       i_avg_sel,
  output logic signed [DATA_W-1:0] o_err,
  output logic signed [DATA_W-1:0] o_dc,
  output logic                     o_valid,
  output logic                     o_abort,
  output logic signed [DATA_W-1:0] o_integ,
  output logic        [2:0]        o_cstate
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_H = 3'd1,
    S_ACQ_H  = 3'd2,
    S_SEEK_L = 3'd3,
    S_WAIT_L = 3'd4,
    S_ACQ_L  = 3'd5,
    S_OUT    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PH_Z = 2'd0,
    PH_H = 2'd1,
    PH_L = 2'd2
  } phase_e;

  logic                     trig_q;
  logic signed [DATA_W-1:0] data_q;
  logic signed [DATA_W-1:0] dither_q;
  logic        [31:0]       wait_q;
  logic        [31:0]       avgsel_q;
  phase_e                   ph_prev_q;
  state_e                   state_q, state_d;
  logic        [31:0]       cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic        [3:0]        shift_q;
  logic signed [DATA_W-1:0] avg_h_q, avg_l_q;
  logic signed [DATA_W-1:0] err_q, err_d;
  logic signed [DATA_W-1:0] dc_q, dc_d;
  logic                     valid_q, valid_d;
  logic                     abort_q;

  phase_e                   ph;
  phase_e                   ph_want;
  logic        [3:0]        shift_sel;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [DATA_W:0]   sum_w, diff_w;

  logic abort, cnt_clr, cnt_inc, acq_start, acc_en, half_done;

  always_comb begin
    if (dither_q > 0)      ph = PH_H;
    else if (dither_q < 0) ph = PH_L;
    else                   ph = PH_Z;
  end

  assign ph_want   = (state_q == S_WAIT_H || state_q == S_ACQ_H) ? PH_H : PH_L;
  assign shift_sel = (avgsel_q > 32'd12) ? 4'd7 : avgsel_q[3:0];
  assign acc_sum   = acc_q + {{(ACC_W-DATA_W){data_q[DATA_W-1]}}, data_q};
  assign acc_shr   = acc_sum >>> shift_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      trig_q    <= 1'b0;
      data_q    <= '0;
      dither_q  <= '0;
      wait_q    <= '0;
      avgsel_q  <= '0;
      ph_prev_q <= PH_Z;
    end else begin
      trig_q    <= i_trig;
      data_q    <= i_data;
      dither_q  <= i_dither;
      wait_q    <= i_wait_cnt;
      avgsel_q  <= i_avg_sel;
      ph_prev_q <= ph;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A phase change always takes priority over a coincident strobe.
  always_comb begin
    state_d   = state_q;
    abort     = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    acq_start = 1'b0;
    acc_en    = 1'b0;
    half_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ph == PH_H && ph_prev_q != PH_H) begin
          cnt_clr = 1'b1;
          state_d = S_WAIT_H;
        end
      end
      S_WAIT_H, S_WAIT_L: begin
        if (ph != ph_want) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == wait_q) begin
          acq_start = 1'b1;
          state_d   = (state_q == S_WAIT_H) ? S_ACQ_H : S_ACQ_L;
        end else if (trig_q) begin
          cnt_inc = 1'b1;
        end
      end
      S_ACQ_H, S_ACQ_L: begin
        if (ph != ph_want) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else if (trig_q) begin
          acc_en = 1'b1;
          if (cnt_q == 32'd1) begin
            half_done = 1'b1;
            state_d   = (state_q == S_ACQ_H) ? S_SEEK_L : S_OUT;
          end
        end
      end
      S_SEEK_L: begin
        if (ph == PH_L && ph_prev_q != PH_L) begin
          cnt_clr = 1'b1;
          state_d = S_WAIT_L;
        end
      end
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_w   = {avg_h_q[DATA_W-1], avg_h_q} + {avg_l_q[DATA_W-1], avg_l_q};
    diff_w  = {avg_h_q[DATA_W-1], avg_h_q} - {avg_l_q[DATA_W-1], avg_l_q};
    valid_d = (state_q == S_OUT);
    err_d   = err_q;
    dc_d    = dc_q;
    if (valid_d) begin
      err_d = DATA_W'(diff_w >>> 1);
      dc_d  = DATA_W'(sum_w >>> 1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      shift_q <= '0;
      avg_h_q <= '0;
      avg_l_q <= '0;
      err_q   <= '0;
      dc_q    <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (cnt_clr)        cnt_q <= '0;
      else if (acq_start) cnt_q <= 32'd1 << shift_sel;
      else if (acc_en)    cnt_q <= cnt_q - 32'd1;
      else if (cnt_inc)   cnt_q <= cnt_q + 32'd1;
      if (acq_start) begin
        acc_q   <= '0;
        shift_q <= shift_sel;
      end else if (acc_en) begin
        acc_q <= acc_sum;
      end
      if (half_done && state_q == S_ACQ_H) avg_h_q <= DATA_W'(acc_shr);
      if (half_done && state_q == S_ACQ_L) avg_l_q <= DATA_W'(acc_shr);
      err_q   <= err_d;
      dc_q    <= dc_d;
      valid_q <= valid_d;
      abort_q <= abort;
    end
  end

`ifdef DEMOD_INTEG_EN
  logic signed [DATA_W-1:0] integ_q;
  logic signed [DATA_W:0]   integ_sum;

  assign integ_sum = {integ_q[DATA_W-1], integ_q} + {err_d[DATA_W-1], err_d};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      integ_q <= '0;
    end else if (valid_d) begin
      if (integ_sum[DATA_W] != integ_sum[DATA_W-1])
        integ_q <= integ_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
      else
        integ_q <= DATA_W'(integ_sum);
    end
  end

  assign o_integ = integ_q;
`else
  assign o_integ = '0;
`endif

  assign o_err    = err_q;
  assign o_dc     = dc_q;
  assign o_valid  = valid_q;
  assign o_abort  = abort_q;
  assign o_cstate = state_q;

endmodule

// File: tb/tb_dither_demod_v1.sv
// Scoreboard bench for dither_demod_v1: directed periods push expected results,
// a negedge monitor pops them on every o_valid.
module tb_dither_demod_v1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               trig = 1'b0;
  logic signed [31:0] data = '0;
  logic signed [31:0] dither = '0;
  logic        [31:0] wait_cnt = '0;
  logic        [31:0] avg_sel = '0;
  logic signed [31:0] o_err, o_dc, o_integ;
  logic               o_valid, o_abort;
  logic        [2:0]  o_cstate;

  dither_demod_v1 #(.DATA_W(32), .ACC_W(48)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_data(data),
    .i_dither(dither), .i_wait_cnt(wait_cnt), .i_avg_sel(avg_sel),
    .o_err(o_err), .o_dc(o_dc), .o_valid(o_valid), .o_abort(o_abort),
    .o_integ(o_integ), .o_cstate(o_cstate)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] err;
    logic signed [31:0] dc;
  } exp_t;

  exp_t               q[$];
  exp_t               e;
  int                 checks = 0;
  int                 failures = 0;
  int                 abort_seen = 0;
  logic signed [31:0] integ_model = '0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic signed [31:0] next_integ(input logic signed [31:0] acc,
                                                    input logic signed [31:0] err);
`ifdef DEMOD_INTEG_EN
    longint s;
    s = longint'(acc) + longint'(err);
    if (s > 64'sd2147483647)  return 32'sh7FFFFFFF;
    if (s < -64'sd2147483648) return 32'sh80000000;
    return 32'(s);
`else
    return 32'sd0 & (acc ^ err);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid actual=1 expected=0 err=%0d dc=%0d", o_err, o_dc);
        end else begin
          e = q.pop_front();
          check("err", o_err, e.err);
          check("dc", o_dc, e.dc);
          integ_model = next_integ(integ_model, e.err);
          check("integ", o_integ, integ_model);
        end
      end
      if (o_abort) abort_seen++;
    end
  end

  task automatic strobe(input logic signed [31:0] d);
    trig = 1'b1;
    data = d;
    @(posedge clk); #1;
    trig = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic half(input logic signed [31:0] dith, input logic signed [31:0] d,
                      input int n);
    dither = dith;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) strobe(d);
  endtask

  task automatic push(input logic signed [31:0] eerr, input logic signed [31:0] edc);
    exp_t x;
    x.err = eerr;
    x.dc  = edc;
    q.push_back(x);
  endtask

  task automatic period(input logic signed [31:0] hd, input logic signed [31:0] ld,
                        input int n, input logic [31:0] w, input logic [31:0] s,
                        input logic signed [31:0] eerr, input logic signed [31:0] edc);
    wait_cnt = w;
    avg_sel  = s;
    push(eerr, edc);
    half(32'sd20, hd, n);
    half(-32'sd20, ld, n);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_err", o_err, 0);
    check("rst_dc", o_dc, 0);
    check("rst_valid", o_valid, 0);
    check("rst_abort", o_abort, 0);
    check("rst_integ", o_integ, 0);
    check("rst_cstate", o_cstate, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    period(32'sd100, 32'sd60, 10, 32'd2, 32'd2, 32'sd20, 32'sd80);
    drain("basic_done");
    period(32'sd100, 32'sd60, 10, 32'd2, 32'd2, 32'sd20, 32'sd80);
    drain("basic2_done");

    period(-32'sd7, -32'sd10, 3, 32'd0, 32'd0, 32'sd1, -32'sd9);
    drain("neg_done");

    period(32'sd5, 32'sd5, 130, 32'd0, 32'd15, 32'sd0, 32'sd5);
    drain("clamp_done");

    wait_cnt = 32'd2;
    avg_sel  = 32'd2;
    push(32'sd20, 32'sd80);
    half(32'sd20, 32'sd100, 10);
    half(32'sd0, 32'sd999, 5);
    half(-32'sd20, 32'sd60, 10);
    drain("gap_done");

    half(32'sd20, 32'sd100, 5);
    half(-32'sd20, 32'sd60, 10);
    repeat (5) @(posedge clk);
    #1;
    check("abort_count", abort_seen, 1);
    check("abort_hold_err", o_err, 32'sd20);
    check("abort_hold_dc", o_dc, 32'sd80);
    period(32'sd200, 32'sd60, 10, 32'd2, 32'd2, 32'sd70, 32'sd130);
    drain("post_abort_done");

    wait_cnt = 32'd2;
    avg_sel  = 32'd2;
    half(32'sd20, 32'sd100, 10);
    half(-32'sd20, 32'sd60, 4);
    check("mid_acq_l_cstate", o_cstate, 5);
    rst_n = 1'b0;
    #2;
    integ_model = '0;
    check("mid_rst_err", o_err, 0);
    check("mid_rst_dc", o_dc, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_abort", o_abort, 0);
    check("mid_rst_integ", o_integ, 0);
    check("mid_rst_cstate", o_cstate, 0);
    dither = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_cstate", o_cstate, 0);
    period(32'sd100, 32'sd60, 10, 32'd2, 32'd2, 32'sd20, 32'sd80);
    drain("post_rst_done");

    for (int k = 0; k < 3; k++) begin
      period(32'sh40000000, -32'sh40000000, 3, 32'd0, 32'd0, 32'sh40000000, 32'sd0);
      drain("sat_done");
    end

    check("abort_total", abort_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
